thinning_window_gen: RTL and testbench

THINNING_WINDOW_GEN -- requirements
Module: thinning_window_gen

---
 rtl/thinning_window_gen_pkg.sv | 23 ++
 rtl/thinning_window_gen_line_buffer.sv | 18 +
 rtl/thinning_window_gen.sv | 103 ++++++++++
 tb/tb_thinning_window_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thinning_window_gen_pkg.sv
// Shared constants for the thinning front end: default image geometry and
// the bit order used for every 3-pixel window row (bit2 = c-1 ... bit0 = c+1).
package thinning_window_gen_pkg;
  localparam int unsigned IMG_W_DEF  = 160;
  localparam int unsigned IMG_H_DEF  = 120;
  localparam int unsigned COL_W      = 8;
  localparam int unsigned ROW_W      = 7;
  localparam int unsigned WIN_LEFT   = 2;
  localparam int unsigned WIN_CENTER = 1;
  localparam int unsigned WIN_RIGHT  = 0;

  typedef logic [2:0] win_row_t;

  // Slide one window row left by a column and insert the newest pixel at c+1.
  function automatic win_row_t win_push(input win_row_t row, input logic newest);
    win_row_t res;
    res             = '0;
    res[WIN_LEFT]   = row[WIN_CENTER];
    res[WIN_CENTER] = row[WIN_RIGHT];
    res[WIN_RIGHT]  = newest;
    return res;
  endfunction
endpackage

// File: rtl/thinning_window_gen_line_buffer.sv
// One-bit, DEPTH-deep shift line buffer; o_dout is the bit pushed DEPTH
// enables ago. Contents are deliberately not reset.
module line_buffer #(
  parameter int unsigned DEPTH = 160
) (
  input  logic clk,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout
);
  logic [DEPTH-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (i_en) r_mem <= {r_mem[DEPTH-2:0], i_din};
  end

  assign o_dout = r_mem[DEPTH-1];
endmodule

// File: rtl/thinning_window_gen.sv
// Raster-order binary pixel stream to 3x3 neighbourhood windows for the
// thinning core; only interior centers raise win_valid.
module thinning_window_gen
  import thinning_window_gen_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic             pix_in,
  output logic [2:0]       top,
  output logic [2:0]       center,
  output logic [2:0]       bottom,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  win_row_t         r_sr_top, r_sr_mid, r_sr_bot;

  logic             w_lb0_out, w_lb1_out;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_col_last, w_row_last, w_win_hit;
  win_row_t         w_top_nxt, w_mid_nxt, w_bot_nxt;

  line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk    (clk),
    .i_en   (pix_valid),
    .i_din  (pix_in),
    .o_dout (w_lb0_out)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk    (clk),
    .i_en   (pix_valid),
    .i_din  (w_lb0_out),
    .o_dout (w_lb1_out)
  );

  // Position of the pixel being accepted; sof overrides the running counters.
  always_comb begin
    w_col      = sof ? '0 : r_col;
    w_row      = sof ? '0 : r_row;
    w_col_last = (w_col == COL_LAST);
    w_row_last = (w_row == ROW_LAST);
    // Accepting (R,C) completes the window centered at (R-1,C-1). Requiring
    // C>=2 also keeps windows from straddling a line wrap.
    w_win_hit  = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
    w_top_nxt  = win_push(r_sr_top, w_lb1_out);
    w_mid_nxt  = win_push(r_sr_mid, w_lb0_out);
    w_bot_nxt  = win_push(r_sr_bot, pix_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_sr_top   <= '0;
      r_sr_mid   <= '0;
      r_sr_bot   <= '0;
      top        <= '0;
      center     <= '0;
      bottom     <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        r_sr_top <= w_top_nxt;
        r_sr_mid <= w_mid_nxt;
        r_sr_bot <= w_bot_nxt;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + ROW_W'(1);
        end else begin
          r_col <= w_col + COL_W'(1);
          r_row <= w_row;
        end
        frame_done <= w_col_last && w_row_last;
        if (w_win_hit) begin
          top       <= w_top_nxt;
          center    <= w_mid_nxt;
          bottom    <= w_bot_nxt;
          win_valid <= 1'b1;
          win_col   <= w_col - COL_W'(1);
          win_row   <= w_row - ROW_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_thinning_window_gen.sv
// Self-checking bench: a frame-array reference model predicts every window
// and frame_done pulse; a negedge monitor records what the DUT produces.
module tb_thinning_window_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0, rst = 1'b1, sof = 1'b0, pix_valid = 1'b0, pix_in = 1'b0;
  logic [2:0] top, center, bottom;
  logic       win_valid, frame_done;
  logic [7:0] win_col;
  logic [6:0] win_row;

  thinning_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
    .top(top), .center(center), .bottom(bottom), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  r;
    logic [7:0]  c;
    logic [2:0]  t;
    logic [2:0]  m;
    logic [2:0]  b;
  } win_t;

  win_t exp_q[$], obs_q[$];
  int   exp_fd[$], obs_fd[$];
  int   errors = 0, checks = 0, consec = 0, cyc = 0, last_sof_cyc = 0;
  int   mr = 0, mc = 0;
  logic prev_wv = 1'b0;
  logic img [0:H-1][0:W-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid)
        obs_q.push_back(win_t'({32'(cyc), {1'b0, win_row}, win_col, top, center, bottom}));
      if (frame_done) obs_fd.push_back(cyc);
      if (win_valid && prev_wv) consec++;
    end
    prev_wv = win_valid;
  end

  // Drives one cycle and advances the reference model if a pixel was offered.
  task automatic drive(input logic s, input logic v, input logic p);
    win_t e;
    sof = s; pix_valid = v; pix_in = p;
    @(posedge clk); #1;
    if (v) begin
      if (s) begin mr = 0; mc = 0; last_sof_cyc = cyc; end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        e = win_t'({32'(cyc), 8'(mr - 1), 8'(mc - 1),
                    img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                    img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                    img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]});
        exp_q.push_back(e);
      end
      mc++;
      if (mc == W) begin
        mc = 0; mr++;
        if (mr == H) begin mr = 0; exp_fd.push_back(cyc); end
      end
    end
    sof = 1'b0; pix_valid = 1'b0; pix_in = 1'b0;
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); exp_fd.delete(); obs_fd.delete(); consec = 0;
  endtask

  task automatic test_reset();
    pix_valid = 1'b1; pix_in = 1'b1; sof = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({top, center, bottom, win_valid, win_col, win_row, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got t=%b m=%b b=%b v=%b col=%0d row=%0d fd=%b required all 0",
               top, center, bottom, win_valid, win_col, win_row, frame_done);
    end
    sof = 1'b0; pix_valid = 1'b0; pix_in = 1'b0;
    rst = 1'b0; mr = 0; mc = 0;
    drive(0, 0, 0);
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got v=%b fd=%b required 0 0", win_valid, frame_done);
    end
    clear_queues();
  endtask

  task automatic test_all_ones();
    clear_queues();
    for (int i = 0; i < W * H; i++) drive(i == 0, 1, 1);
    repeat (3) drive(0, 0, 0);
    checks++;
    if (obs_q.size() != 6) begin
      errors++;
      $display("FAIL ones_count: got %0d windows required 6", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 6; k++) begin
      checks++;
      if (obs_q[k].r != 8'(1 + k / 3) || obs_q[k].c != 8'(1 + k % 3) ||
          {obs_q[k].t, obs_q[k].m, obs_q[k].b} !== 9'h1FF) begin
        errors++;
        $display("FAIL ones_win[%0d]: got r=%0d c=%0d t=%b m=%b b=%b required r=%0d c=%0d all 111",
                 k, obs_q[k].r, obs_q[k].c, obs_q[k].t, obs_q[k].m, obs_q[k].b, 1 + k / 3, 1 + k % 3);
      end
    end
    checks++;
    if (obs_fd.size() != 1 || exp_fd.size() != 1 || obs_fd[0] != exp_fd[0]) begin
      errors++;
      $display("FAIL ones_frame_done: got %0d pulses required 1 at cycle %0d",
               obs_fd.size(), (exp_fd.size() > 0) ? exp_fd[0] : -1);
    end
    checks++;
    if (win_valid !== 1'b0 || {top, center, bottom} !== 9'h1FF || win_row !== 7'd2 || win_col !== 8'd3) begin
      errors++;
      $display("FAIL ones_hold: got v=%b t=%b m=%b b=%b row=%0d col=%0d required 0 111 111 111 2 3",
               win_valid, top, center, bottom, win_row, win_col);
    end
  endtask

  task automatic test_single_dot();
    int found;
    clear_queues();
    for (int i = 0; i < W * H; i++) drive(i == 0, 1, i == W + 1);
    repeat (3) drive(0, 0, 0);
    found = 0;
    foreach (obs_q[k]) begin
      if (obs_q[k].r == 8'd1 && obs_q[k].c == 8'd1) begin
        found++;
        checks++;
        if ({obs_q[k].t, obs_q[k].m, obs_q[k].b} !== 9'b000_010_000) begin
          errors++;
          $display("FAIL dot_win11: got t=%b m=%b b=%b required 000 010 000",
                   obs_q[k].t, obs_q[k].m, obs_q[k].b);
        end
      end
      if (obs_q[k].r == 8'd2 && obs_q[k].c == 8'd2) begin
        found++;
        checks++;
        if (obs_q[k].t !== 3'b100 || obs_q[k].m !== 3'b000 || obs_q[k].b !== 3'b000) begin
          errors++;
          $display("FAIL dot_win22: got t=%b m=%b b=%b required 100 000 000",
                   obs_q[k].t, obs_q[k].m, obs_q[k].b);
        end
      end
    end
    checks++;
    if (found != 2) begin
      errors++;
      $display("FAIL dot_found: got %0d of windows (1,1),(2,2) required 2", found);
    end
  endtask

  task automatic test_toggle_valid();
    clear_queues();
    for (int i = 0; i < W * H; i++) begin
      drive(i == 0, 1, 1);
      drive(0, 0, 0);
    end
    repeat (3) drive(0, 0, 0);
    checks++;
    if (obs_q.size() != 6 || exp_q.size() != 6) begin
      errors++;
      $display("FAIL toggle_count: got %0d windows required 6", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL toggle_win[%0d]: got cyc=%0d r=%0d c=%0d t=%b m=%b b=%b required cyc=%0d r=%0d c=%0d t=%b m=%b b=%b",
                 k, obs_q[k].cyc, obs_q[k].r, obs_q[k].c, obs_q[k].t, obs_q[k].m, obs_q[k].b,
                 exp_q[k].cyc, exp_q[k].r, exp_q[k].c, exp_q[k].t, exp_q[k].m, exp_q[k].b);
      end
    end
    checks++;
    if (consec != 0) begin
      errors++;
      $display("FAIL toggle_consecutive: got %0d back-to-back win_valid required 0", consec);
    end
  endtask

  task automatic test_sof_restart();
    clear_queues();
    for (int i = 0; i < 7; i++) drive(i == 0, 1, 1);
    for (int i = 0; i < W * H; i++) drive(i == 0, 1, 1);
    repeat (3) drive(0, 0, 0);
    checks++;
    if (obs_q.size() == 0 || obs_q[0].r != 8'd1 || obs_q[0].c != 8'd1 ||
        obs_q[0].cyc != 32'(last_sof_cyc + 12)) begin
      errors++;
      $display("FAIL sof_first_win: got n=%0d r=%0d c=%0d cyc=%0d required r=1 c=1 cyc=%0d",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].r : 0, (obs_q.size() > 0) ? obs_q[0].c : 0,
               (obs_q.size() > 0) ? obs_q[0].cyc : 0, last_sof_cyc + 12);
    end
    checks++;
    if (obs_q.size() != exp_q.size() || obs_fd.size() != 1) begin
      errors++;
      $display("FAIL sof_counts: got %0d windows %0d frame_done required %0d windows 1 frame_done",
               obs_q.size(), obs_fd.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    clear_queues();
    for (int i = 0; i < 10; i++) drive(i == 0, 1, 1);
    rst = 1'b1;
    #1;
    checks++;
    if ({top, center, bottom, win_valid, win_col, win_row, frame_done} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got t=%b m=%b b=%b v=%b col=%0d row=%0d fd=%b required all 0",
               top, center, bottom, win_valid, win_col, win_row, frame_done);
    end
    drive(0, 1, 1);
    drive(1, 1, 1);
    checks++;
    if ({top, center, bottom, win_valid, win_col, win_row, frame_done} !== '0) begin
      errors++;
      $display("FAIL midreset_held: got t=%b m=%b b=%b v=%b col=%0d row=%0d fd=%b required all 0",
               top, center, bottom, win_valid, win_col, win_row, frame_done);
    end
    rst = 1'b0; mr = 0; mc = 0;
    clear_queues();
    for (int i = 0; i < W * H; i++) drive(0, 1, 1'($urandom_range(1)));
    repeat (3) drive(0, 0, 0);
    checks++;
    if (obs_q.size() != 6 || obs_fd.size() != 1) begin
      errors++;
      $display("FAIL midreset_counts: got %0d windows %0d frame_done required 6 and 1",
               obs_q.size(), obs_fd.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL midreset_win[%0d]: got cyc=%0d r=%0d c=%0d t=%b m=%b b=%b required cyc=%0d r=%0d c=%0d t=%b m=%b b=%b",
                 k, obs_q[k].cyc, obs_q[k].r, obs_q[k].c, obs_q[k].t, obs_q[k].m, obs_q[k].b,
                 exp_q[k].cyc, exp_q[k].r, exp_q[k].c, exp_q[k].t, exp_q[k].m, exp_q[k].b);
      end
    end
  endtask

  task automatic test_random();
    int acc;
    logic v;
    clear_queues();
    for (int f = 0; f < 4; f++) begin
      acc = 0;
      while (acc < W * H) begin
        v = ($urandom_range(3) != 0);
        if (v) begin
          drive((acc == 0) && (f % 2 == 0), 1, 1'($urandom_range(1)));
          acc++;
        end else begin
          drive(1'($urandom_range(1)), 0, 1'($urandom_range(1)));
        end
      end
    end
    repeat (3) drive(0, 0, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d windows required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rand_win[%0d]: got cyc=%0d r=%0d c=%0d t=%b m=%b b=%b required cyc=%0d r=%0d c=%0d t=%b m=%b b=%b",
                 k, obs_q[k].cyc, obs_q[k].r, obs_q[k].c, obs_q[k].t, obs_q[k].m, obs_q[k].b,
                 exp_q[k].cyc, exp_q[k].r, exp_q[k].c, exp_q[k].t, exp_q[k].m, exp_q[k].b);
      end
    end
    checks++;
    if (obs_fd.size() != exp_fd.size()) begin
      errors++;
      $display("FAIL rand_fd_count: got %0d pulses required %0d", obs_fd.size(), exp_fd.size());
    end
    for (int k = 0; k < obs_fd.size() && k < exp_fd.size(); k++) begin
      checks++;
      if (obs_fd[k] != exp_fd[k]) begin
        errors++;
        $display("FAIL rand_fd[%0d]: got cycle %0d required cycle %0d", k, obs_fd[k], exp_fd[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_dot();
    test_toggle_valid();
    test_sof_restart();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
